// File: rtl/gullfaxi_rx_port.sv
// Gullfaxi output-port receiver: grants a switch request only when a
// worst-case packet fits, captures and length-checks the packet, and commits
// good packets into a store-and-forward FIFO drained as a valid/ready stream.
module gullfaxi_rx_port #(
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 8,
  parameter int DEPTH   = 512,
  parameter int MAX_PKT = 255,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              o_req,
  output logic              o_grant,
  input  logic              o_start,
  input  logic [LEN_W-1:0]  o_length,
  input  logic [DATA_W-1:0] o_data,
  input  logic              o_end,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic [15:0]       pkt_count,
  output logic              err_len,
  output logic              err_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RECV,
    DISCARD
  } state_t;

  state_t            state;
  logic [PW-1:0]     wr_spec;
  logic [PW-1:0]     wr_com;
  logic [PW-1:0]     rd_ptr;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt;
  logic [TW-1:0]     tmo;

  logic [DATA_W:0]   mem [DEPTH];

  logic [PW-1:0]     used;
  logic [PW-1:0]     free;
  logic              free_ok;
  logic              len_bad;
  logic [LEN_W-1:0]  cnt_inc;
  logic              wr_en;
  logic              wr_last;
  logic [DATA_W:0]   head;

  // Space accounting, length legality and FIFO write qualification.
  always_comb begin
    used    = wr_spec - rd_ptr;
    free    = PW'(DEPTH) - used;
    free_ok = (free >= PW'(MAX_PKT));
    len_bad = (o_length == '0) || ({1'b0, o_length} > (LEN_W + 1)'(MAX_PKT));
    cnt_inc = cnt + LEN_W'(1);
    wr_en   = 1'b0;
    wr_last = 1'b0;
    case (state)
      GRANT: begin
        wr_en   = o_start;
        wr_last = o_start && o_end && !len_bad && (o_length == LEN_W'(1));
      end
      RECV: begin
        wr_en   = 1'b1;
        wr_last = o_end && (cnt_inc == len_q);
      end
      default: ;
    endcase
  end

  // FIFO storage: data word plus last flag, written at the speculative pointer.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_spec[AW-1:0]] <= {wr_last, o_data};
    end
  end

  // Read side only ever sees committed words; outputs forced to 0 when empty.
  always_comb begin
    head    = mem[rd_ptr[AW-1:0]];
    m_valid = (wr_com != rd_ptr);
    m_data  = m_valid ? head[DATA_W-1:0] : '0;
    m_last  = m_valid ? head[DATA_W] : 1'b0;
  end

  // Receive FSM with commit/rollback of the speculative pointer and read advance.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      wr_spec     <= '0;
      wr_com      <= '0;
      rd_ptr      <= '0;
      len_q       <= '0;
      cnt         <= '0;
      tmo         <= '0;
      o_grant     <= 1'b0;
      pkt_count   <= '0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_len     <= 1'b0;
      err_timeout <= 1'b0;

      if (m_valid && m_ready) begin
        rd_ptr <= rd_ptr + PW'(1);
      end

      case (state)
        IDLE: begin
          if (o_req && free_ok) begin
            state   <= GRANT;
            o_grant <= 1'b1;
            tmo     <= TW'(TIMEOUT);
          end
        end

        GRANT: begin
          if (o_start) begin
            len_q <= o_length;
            if (len_bad) begin
              err_len <= 1'b1;
              wr_spec <= wr_com;
              if (o_end) begin
                state   <= IDLE;
                o_grant <= 1'b0;
              end else begin
                state <= DISCARD;
              end
            end else if (o_end) begin
              if (o_length == LEN_W'(1)) begin
                wr_spec   <= wr_spec + PW'(1);
                wr_com    <= wr_spec + PW'(1);
                pkt_count <= pkt_count + 16'd1;
              end else begin
                err_len <= 1'b1;
                wr_spec <= wr_com;
              end
              state   <= IDLE;
              o_grant <= 1'b0;
            end else begin
              wr_spec <= wr_spec + PW'(1);
              cnt     <= LEN_W'(1);
              state   <= RECV;
            end
          end else if (tmo == TW'(1)) begin
            // Counter would reach 0 on this edge: give up on the packet.
            err_timeout <= 1'b1;
            state       <= IDLE;
            o_grant     <= 1'b0;
          end else begin
            tmo <= tmo - TW'(1);
          end
        end

        RECV: begin
          if (o_end) begin
            if (cnt_inc == len_q) begin
              wr_spec   <= wr_spec + PW'(1);
              wr_com    <= wr_spec + PW'(1);
              pkt_count <= pkt_count + 16'd1;
            end else begin
              err_len <= 1'b1;
              wr_spec <= wr_com;
            end
            state   <= IDLE;
            o_grant <= 1'b0;
          end else if (cnt_inc == len_q) begin
            err_len <= 1'b1;
            wr_spec <= wr_com;
            state   <= DISCARD;
          end else begin
            wr_spec <= wr_spec + PW'(1);
            cnt     <= cnt_inc;
          end
        end

        DISCARD: begin
          if (o_end) begin
            state   <= IDLE;
            o_grant <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          o_grant <= 1'b0;
        end
      endcase
    end
  end

endmodule
